// File: rtl/shim_spi_boot_seq_pkg.sv
// Shared types and constants for the SPI-domain boot self-test sequencer.
// Holds the FSM state encoding (also visible on the seq_state status port),
// the integrator config reset defaults and the default number of test slots.
package shim_boot_seq_pkg;

    // Encoding is software-visible through seq_state; do not renumber.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCAN  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HOLD  = 3'd4,
        ST_RUN   = 3'd5,
        ST_FAULT = 3'd6
    } seq_state_e;

    localparam int NUM_TESTS_DEF = 16;

    localparam int THRESH_W = 15;
    localparam int WINDOW_W = 32;

    localparam logic [THRESH_W-1:0] INTEG_THRESH_DEF = 15'h1000;
    localparam logic [WINDOW_W-1:0] INTEG_WINDOW_DEF = 32'h0001_0000;

endpackage

// File: rtl/shim_spi_boot_seq_if.sv
// Handshake between the boot sequencer and the per-channel test engine.
// Ports: test_start/test_idx (sequencer -> engine), test_done/test_pass
// (engine -> sequencer, test_pass qualified by the test_done strobe).
interface shim_spi_boot_seq_if #(
    parameter int IDX_W = 4
);
    logic             test_start;
    logic [IDX_W-1:0] test_idx;
    logic             test_done;
    logic             test_pass;

    // Sequencer side.
    modport master (
        output test_start,
        output test_idx,
        input  test_done,
        input  test_pass
    );

    // Test engine side.
    modport slave (
        input  test_start,
        input  test_idx,
        output test_done,
        output test_pass
    );

endinterface

// File: rtl/shim_spi_boot_seq_cfg_shadow.sv
// Load-when-idle hold register for one integrator config field.
// Ports: clk_i, rst_i (sync, active-high), hold_i (1 = freeze), data_i, data_o.
// Loads data_i every cycle hold_i is low; one-cycle latency from data_i to data_o.
module shim_cfg_shadow #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] DEFAULT = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             hold_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (!hold_i) begin
            data_d = data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= DEFAULT;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/shim_spi_boot_seq.sv
// Boot self-test sequencer: walks test slots, gates spi_run/bufs_open on all
// non-skipped tests passing, and owns the frozen-while-running integrator config.
// Ports: spi_clk/spi_rst, synchronized enables and masks, test handshake (tst),
// debug_step, datapath gates, active integrator config, status/sticky flags.
// Optional build macro BOOT_TEST_RETRY_EN: each test may fail once and is re-run
// before the sequencer faults; without it any failure faults immediately.
module shim_spi_boot_seq
    import shim_boot_seq_pkg::*;
#(
    parameter int NUM_TESTS      = NUM_TESTS_DEF,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int IDX_W          = $clog2(NUM_TESTS)
) (
    input  logic                 spi_clk,
    input  logic                 spi_rst,

    input  logic                 spi_en_sync,
    input  logic                 block_bufs_sync,
    input  logic [NUM_TESTS-1:0] boot_test_skip_sync,
    input  logic [NUM_TESTS-1:0] boot_test_debug_sync,
    input  logic [THRESH_W-1:0]  integ_thresh_avg_sync,
    input  logic [WINDOW_W-1:0]  integ_window_sync,
    input  logic                 integ_en_sync,

    shim_spi_boot_seq_if.master  tst,
    input  logic                 debug_step,

    output logic                 spi_run,
    output logic                 bufs_open,
    output logic                 integ_en_act,
    output logic [THRESH_W-1:0]  integ_thresh_avg_act,
    output logic [WINDOW_W-1:0]  integ_window_act,
    output logic [2:0]           seq_state,
    output logic                 boot_fail,
    output logic                 boot_timeout,
    output logic [IDX_W-1:0]     fail_idx
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    // idx needs one extra bit so it can reach NUM_TESTS (the "all done" mark).
    localparam logic [IDX_W:0]   IDX_END = (IDX_W+1)'(NUM_TESTS);
    localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT_CYCLES - 1);

    seq_state_e       state_q, state_d;
    logic [IDX_W:0]   idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             boot_fail_q, boot_fail_d;
    logic             boot_timeout_q, boot_timeout_d;
    logic [IDX_W-1:0] fail_idx_q, fail_idx_d;
    logic             bufs_open_q, bufs_open_d;
    logic             integ_en_act_q, integ_en_act_d;

    logic             fail_now;
    logic             fail_is_to;
    logic [IDX_W-1:0] slot;

`ifdef BOOT_TEST_RETRY_EN
    logic             retry_q, retry_d;
`endif

    assign slot = idx_q[IDX_W-1:0];

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        cnt_d          = cnt_q;
        boot_fail_d    = boot_fail_q;
        boot_timeout_d = boot_timeout_q;
        fail_idx_d     = fail_idx_q;
        fail_now       = 1'b0;
        fail_is_to     = 1'b0;
`ifdef BOOT_TEST_RETRY_EN
        retry_d        = retry_q;
`endif

        if (state_q != ST_IDLE && !spi_en_sync) begin
            // Abort: any in-flight test is abandoned; a late test_done lands in
            // IDLE where it has no effect.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (spi_en_sync) begin
                        state_d        = ST_SCAN;
                        idx_d          = '0;
                        boot_fail_d    = 1'b0;
                        boot_timeout_d = 1'b0;
                        fail_idx_d     = '0;
                    end
                end
                ST_SCAN: begin
                    if (idx_q == IDX_END) begin
                        state_d = ST_RUN;
                    end else if (boot_test_skip_sync[slot]) begin
                        idx_d = idx_q + (IDX_W+1)'(1);
                    end else begin
                        state_d = ST_START;
                    end
                end
                ST_START: begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    // test_done is checked first so it wins over a coincident timeout.
                    if (tst.test_done) begin
                        if (!tst.test_pass) begin
                            fail_now = 1'b1;
                        end else if (boot_test_debug_sync[slot]) begin
                            state_d = ST_HOLD;
                        end else begin
                            idx_d   = idx_q + (IDX_W+1)'(1);
                            state_d = ST_SCAN;
                        end
                    end else if (cnt_q == CNT_TO) begin
                        fail_now   = 1'b1;
                        fail_is_to = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (debug_step) begin
                        idx_d   = idx_q + (IDX_W+1)'(1);
                        state_d = ST_SCAN;
                    end
                end
                ST_RUN:   state_d = ST_RUN;
                ST_FAULT: state_d = ST_FAULT;
                default:  state_d = ST_IDLE;
            endcase

            if (fail_now) begin
`ifdef BOOT_TEST_RETRY_EN
                if (!retry_q) begin
                    retry_d = 1'b1;
                    state_d = ST_START;
                end else
`endif
                begin
                    state_d        = ST_FAULT;
                    boot_fail_d    = 1'b1;
                    boot_timeout_d = fail_is_to;
                    fail_idx_d     = slot;
                end
            end
        end

`ifdef BOOT_TEST_RETRY_EN
        // Retry budget is per test: rearm whenever the slot pointer moves or
        // a fresh boot pass begins.
        if (idx_d != idx_q || state_q == ST_IDLE) begin
            retry_d = 1'b0;
        end
`endif

        // Keyed on the next state so the gates fall in the same edge that
        // leaves RUN, and track their inputs with one cycle of latency in RUN.
        bufs_open_d    = (state_d == ST_RUN) && !block_bufs_sync;
        integ_en_act_d = (state_d == ST_RUN) && integ_en_sync;
    end

    always_ff @(posedge spi_clk) begin
        if (spi_rst) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            cnt_q          <= '0;
            boot_fail_q    <= 1'b0;
            boot_timeout_q <= 1'b0;
            fail_idx_q     <= '0;
            bufs_open_q    <= 1'b0;
            integ_en_act_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            cnt_q          <= cnt_d;
            boot_fail_q    <= boot_fail_d;
            boot_timeout_q <= boot_timeout_d;
            fail_idx_q     <= fail_idx_d;
            bufs_open_q    <= bufs_open_d;
            integ_en_act_q <= integ_en_act_d;
        end
    end

`ifdef BOOT_TEST_RETRY_EN
    always_ff @(posedge spi_clk) begin
        if (spi_rst) begin
            retry_q <= 1'b0;
        end else begin
            retry_q <= retry_d;
        end
    end
`endif

    // Active integrator config follows the synchronized inputs while the
    // integrator is off and freezes while it runs.
    shim_cfg_shadow #(
        .WIDTH   (THRESH_W),
        .DEFAULT (INTEG_THRESH_DEF)
    ) u_thresh_shadow (
        .clk_i  (spi_clk),
        .rst_i  (spi_rst),
        .hold_i (integ_en_act_q),
        .data_i (integ_thresh_avg_sync),
        .data_o (integ_thresh_avg_act)
    );

    shim_cfg_shadow #(
        .WIDTH   (WINDOW_W),
        .DEFAULT (INTEG_WINDOW_DEF)
    ) u_window_shadow (
        .clk_i  (spi_clk),
        .rst_i  (spi_rst),
        .hold_i (integ_en_act_q),
        .data_i (integ_window_sync),
        .data_o (integ_window_act)
    );

    assign tst.test_start = (state_q == ST_START);
    assign tst.test_idx   = slot;

    assign spi_run      = (state_q == ST_RUN);
    assign bufs_open    = bufs_open_q;
    assign integ_en_act = integ_en_act_q;
    assign seq_state    = state_q;
    assign boot_fail    = boot_fail_q;
    assign boot_timeout = boot_timeout_q;
    assign fail_idx     = fail_idx_q;

endmodule

// File: tb/tb_shim_spi_boot_seq.sv
// Directed bench for shim_spi_boot_seq (NUM_TESTS=16, TIMEOUT_CYCLES=8).
// Inputs are driven and outputs sampled on the falling edge of spi_clk.
module tb_shim_spi_boot_seq;

    localparam int NT    = 16;
    localparam int TO    = 8;
    localparam int IW    = 4;

    localparam int S_IDLE  = 0;
    localparam int S_SCAN  = 1;
    localparam int S_START = 2;
    localparam int S_WAIT  = 3;
    localparam int S_HOLD  = 4;
    localparam int S_RUN   = 5;
    localparam int S_FAULT = 6;

    logic          spi_clk;
    logic          spi_rst;
    logic          spi_en_sync;
    logic          block_bufs_sync;
    logic [NT-1:0] boot_test_skip_sync;
    logic [NT-1:0] boot_test_debug_sync;
    logic [14:0]   integ_thresh_avg_sync;
    logic [31:0]   integ_window_sync;
    logic          integ_en_sync;
    logic          debug_step;
    logic          spi_run;
    logic          bufs_open;
    logic          integ_en_act;
    logic [14:0]   integ_thresh_avg_act;
    logic [31:0]   integ_window_act;
    logic [2:0]    seq_state;
    logic          boot_fail;
    logic          boot_timeout;
    logic [IW-1:0] fail_idx;

    shim_spi_boot_seq_if #(.IDX_W(IW)) tst_if ();

    shim_spi_boot_seq #(
        .NUM_TESTS      (NT),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .spi_clk               (spi_clk),
        .spi_rst               (spi_rst),
        .spi_en_sync           (spi_en_sync),
        .block_bufs_sync       (block_bufs_sync),
        .boot_test_skip_sync   (boot_test_skip_sync),
        .boot_test_debug_sync  (boot_test_debug_sync),
        .integ_thresh_avg_sync (integ_thresh_avg_sync),
        .integ_window_sync     (integ_window_sync),
        .integ_en_sync         (integ_en_sync),
        .tst                   (tst_if),
        .debug_step            (debug_step),
        .spi_run               (spi_run),
        .bufs_open             (bufs_open),
        .integ_en_act          (integ_en_act),
        .integ_thresh_avg_act  (integ_thresh_avg_act),
        .integ_window_act      (integ_window_act),
        .seq_state             (seq_state),
        .boot_fail             (boot_fail),
        .boot_timeout          (boot_timeout),
        .fail_idx              (fail_idx)
    );

    int n_chk;
    int n_bad;
    int n_starts;

    initial spi_clk = 1'b0;
    always #5 spi_clk = ~spi_clk;

    always @(negedge spi_clk) begin
        if (tst_if.test_start === 1'b1) n_starts++;
    end

    task automatic tick();
        @(negedge spi_clk);
    endtask

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_start(input string tag, input int max);
        int n;
        n = 0;
        while (tst_if.test_start !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        chk_eq(tag, 32'(tst_if.test_start), 32'd1);
    endtask

    task automatic wait_state(input string tag, input int target, input int max);
        int n;
        n = 0;
        while (32'(seq_state) != target && n < max) begin
            tick();
            n++;
        end
        chk_eq(tag, 32'(seq_state), target);
    endtask

    task automatic done_pulse(input logic pass);
        tst_if.test_done = 1'b1;
        tst_if.test_pass = pass;
        tick();
        tst_if.test_done = 1'b0;
        tst_if.test_pass = 1'b0;
    endtask

    initial begin
        int scans;
        int waits;
        int holds;
        int s0;

        n_chk = 0;
        n_bad = 0;
        n_starts = 0;
        spi_rst               = 1'b1;
        spi_en_sync           = 1'b0;
        block_bufs_sync       = 1'b0;
        boot_test_skip_sync   = '1;
        boot_test_debug_sync  = '0;
        integ_thresh_avg_sync = 15'h0123;
        integ_window_sync     = 32'hCAFE_0000;
        integ_en_sync         = 1'b0;
        debug_step            = 1'b0;
        tst_if.test_done      = 1'b0;
        tst_if.test_pass      = 1'b0;

        // Reset values
        repeat (3) tick();
        chk_eq("rst_state", 32'(seq_state), S_IDLE);
        chk_eq("rst_run", 32'(spi_run), 0);
        chk_eq("rst_bufs", 32'(bufs_open), 0);
        chk_eq("rst_start", 32'(tst_if.test_start), 0);
        chk_eq("rst_idx", 32'(tst_if.test_idx), 0);
        chk_eq("rst_fail", 32'(boot_fail), 0);
        chk_eq("rst_failidx", 32'(fail_idx), 0);
        chk_eq("rst_thresh", 32'(integ_thresh_avg_act), 32'h1000);
        chk_eq("rst_window", integ_window_act, 32'h0001_0000);
        spi_rst = 1'b0;
        tick();
        chk_eq("idle_load_window", integ_window_act, 32'hCAFE_0000);
        chk_eq("idle_load_thresh", 32'(integ_thresh_avg_act), 32'h0123);

        // All tests skipped: 17 SCAN cycles then RUN, no test_start
        s0 = n_starts;
        spi_en_sync = 1'b1;
        scans = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (32'(seq_state) == S_SCAN) scans++;
            if (32'(seq_state) == S_RUN) break;
        end
        chk_eq("skipall_scans", scans, 17);
        chk_eq("skipall_state", 32'(seq_state), S_RUN);
        chk_eq("skipall_run", 32'(spi_run), 1);
        chk_eq("skipall_starts", n_starts - s0, 0);
        spi_en_sync = 1'b0;
        tick();
        chk_eq("abort_state", 32'(seq_state), S_IDLE);
        chk_eq("abort_run", 32'(spi_run), 0);
        chk_eq("abort_bufs", 32'(bufs_open), 0);

        // Test 0 passes five cycles after start; bufs_open tracks !block_bufs
        s0 = n_starts;
        boot_test_skip_sync = 16'hFFFE;
        block_bufs_sync = 1'b1;
        spi_en_sync = 1'b1;
        wait_start("t0_start", 20);
        chk_eq("t0_idx", 32'(tst_if.test_idx), 0);
        repeat (4) tick();
        chk_eq("t0_wait", 32'(seq_state), S_WAIT);
        tick();
        done_pulse(1'b1);
        wait_state("t0_run", S_RUN, 40);
        chk_eq("t0_starts", n_starts - s0, 1);
        chk_eq("t0_bufs_blocked", 32'(bufs_open), 0);
        block_bufs_sync = 1'b0;
        tick();
        chk_eq("t0_bufs_open", 32'(bufs_open), 1);
        block_bufs_sync = 1'b1;
        tick();
        chk_eq("t0_bufs_close", 32'(bufs_open), 0);
        spi_en_sync = 1'b0;
        tick();

        // Test 2 fails
        boot_test_skip_sync = 16'hFFFB;
        spi_en_sync = 1'b1;
        wait_start("t2_start", 20);
        chk_eq("t2_idx", 32'(tst_if.test_idx), 2);
        tick();
        done_pulse(1'b0);
`ifdef BOOT_TEST_RETRY_EN
        chk_eq("t2_retry_start", 32'(tst_if.test_start), 1);
        chk_eq("t2_retry_idx", 32'(tst_if.test_idx), 2);
        tick();
        done_pulse(1'b0);
`endif
        chk_eq("t2_fault", 32'(seq_state), S_FAULT);
        chk_eq("t2_fail", 32'(boot_fail), 1);
        chk_eq("t2_to", 32'(boot_timeout), 0);
        chk_eq("t2_failidx", 32'(fail_idx), 2);
        chk_eq("t2_run", 32'(spi_run), 0);
        repeat (3) tick();
        chk_eq("t2_fault_stays", 32'(seq_state), S_FAULT);
        spi_en_sync = 1'b0;
        tick();
        chk_eq("t2_idle", 32'(seq_state), S_IDLE);
        chk_eq("t2_fail_held", 32'(boot_fail), 1);
        chk_eq("t2_failidx_held", 32'(fail_idx), 2);
        boot_test_skip_sync = 16'hFFFF;
        spi_en_sync = 1'b1;
        tick();
        chk_eq("t2_rearm_scan", 32'(seq_state), S_SCAN);
        chk_eq("t2_fail_clr", 32'(boot_fail), 0);
        chk_eq("t2_failidx_clr", 32'(fail_idx), 0);
        spi_en_sync = 1'b0;
        tick();

        // Timeout: no test_done
        boot_test_skip_sync = 16'hFFFE;
        spi_en_sync = 1'b1;
        wait_start("to_start", 20);
        waits = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (32'(seq_state) != S_WAIT) break;
            waits++;
        end
`ifdef BOOT_TEST_RETRY_EN
        chk_eq("to_retry_start", 32'(seq_state), S_START);
        waits = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (32'(seq_state) != S_WAIT) break;
            waits++;
        end
`endif
        chk_eq("to_waits", waits, TO);
        chk_eq("to_fault", 32'(seq_state), S_FAULT);
        chk_eq("to_flag", 32'(boot_timeout), 1);
        chk_eq("to_fail", 32'(boot_fail), 1);
        spi_en_sync = 1'b0;
        tick();

        // test_done on the timeout cycle: pass wins
        spi_en_sync = 1'b1;
        wait_start("tie_start", 20);
        repeat (8) tick();
        chk_eq("tie_wait", 32'(seq_state), S_WAIT);
        done_pulse(1'b1);
        chk_eq("tie_scan", 32'(seq_state), S_SCAN);
        wait_state("tie_run", S_RUN, 40);
        chk_eq("tie_no_to", 32'(boot_timeout), 0);
        chk_eq("tie_no_fail", 32'(boot_fail), 0);
        spi_en_sync = 1'b0;
        tick();

        // Debug hold after test 0
        boot_test_debug_sync = 16'h0001;
        spi_en_sync = 1'b1;
        wait_start("dbg_start", 20);
        tick();
        done_pulse(1'b1);
        holds = 0;
        for (int i = 0; i < 100; i++) begin
            if (32'(seq_state) == S_HOLD) holds++;
            tick();
        end
        chk_eq("dbg_hold_cycles", holds, 100);
        chk_eq("dbg_hold_idx", 32'(tst_if.test_idx), 0);
        debug_step = 1'b1;
        tick();
        debug_step = 1'b0;
        chk_eq("dbg_step_scan", 32'(seq_state), S_SCAN);
        chk_eq("dbg_step_idx", 32'(tst_if.test_idx), 1);
        wait_state("dbg_run", S_RUN, 40);
        boot_test_debug_sync = '0;

        // Integrator config frozen while the integrator runs
        integ_window_sync = 32'h1111_2222;
        integ_thresh_avg_sync = 15'h0AAA;
        integ_en_sync = 1'b1;
        tick();
        chk_eq("int_en_act", 32'(integ_en_act), 1);
        chk_eq("int_window_cap", integ_window_act, 32'h1111_2222);
        integ_window_sync = 32'h3333_4444;
        integ_thresh_avg_sync = 15'h0555;
        repeat (2) tick();
        chk_eq("int_window_frozen", integ_window_act, 32'h1111_2222);
        chk_eq("int_thresh_frozen", 32'(integ_thresh_avg_act), 32'h0AAA);
        integ_en_sync = 1'b0;
        tick();
        chk_eq("int_en_drop", 32'(integ_en_act), 0);
        chk_eq("int_window_1cyc", integ_window_act, 32'h1111_2222);
        tick();
        chk_eq("int_window_2cyc", integ_window_act, 32'h3333_4444);
        spi_en_sync = 1'b0;
        tick();

        // Abort during a test; the late test_done is ignored
        spi_en_sync = 1'b1;
        wait_start("ab_start", 20);
        tick();
        spi_en_sync = 1'b0;
        tick();
        chk_eq("ab_idle", 32'(seq_state), S_IDLE);
        done_pulse(1'b0);
        chk_eq("ab_late_done_state", 32'(seq_state), S_IDLE);
        chk_eq("ab_late_done_fail", 32'(boot_fail), 0);

        // Reset mid-operation
        boot_test_skip_sync = 16'hFFFF;
        spi_en_sync = 1'b1;
        integ_en_sync = 1'b1;
        wait_state("mr_run", S_RUN, 40);
        tick();
        chk_eq("mr_int_en", 32'(integ_en_act), 1);
        spi_rst = 1'b1;
        tick();
        chk_eq("mr_state", 32'(seq_state), S_IDLE);
        chk_eq("mr_run_off", 32'(spi_run), 0);
        chk_eq("mr_int_off", 32'(integ_en_act), 0);
        chk_eq("mr_window", integ_window_act, 32'h0001_0000);
        chk_eq("mr_thresh", 32'(integ_thresh_avg_act), 32'h1000);
        spi_en_sync = 1'b0;
        integ_en_sync = 1'b0;
        spi_rst = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
